// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: general registers R2/R4/R5/R6, PC, IR,
// MAR, MDR, Y, a double-width Z result register and a combinational ALU.
// Every transfer goes over one shared bus, which is exported for observation.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [WIDTH-1:0] MData_In,
  input  logic             Read,
  input  logic [4:0]       CONTROL,
  input  logic             IncPC,
  input  logic             PC_Out,
  input  logic             ZHI_Out,
  input  logic             ZLO_Out,
  input  logic             MDR_Out,
  input  logic             R2_Out,
  input  logic             R4_Out,
  input  logic             PC_In,
  input  logic             IR_In,
  input  logic             MAR_In,
  input  logic             MDR_In,
  input  logic             Y_In,
  input  logic             Z_In,
  input  logic             R2_In,
  input  logic             R4_In,
  input  logic             R5_In,
  input  logic             R6_In,
  output logic [WIDTH-1:0] BusMux_Out
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_NEG = 5'b00101;
  localparam logic [4:0] OP_NOT = 5'b00110;

  logic [WIDTH-1:0]   r_r2, r_r4, r_r5, r_r6;
  logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y;
  logic [2*WIDTH-1:0] r_z;

  logic [WIDTH-1:0]          w_bus;
  logic [WIDTH-1:0]          w_mdr_src;
  logic [2*WIDTH-1:0]        w_alu;
  logic signed [WIDTH-1:0]   w_a_s;
  logic signed [WIDTH-1:0]   w_b_s;
  logic signed [2*WIDTH-1:0] w_prod;
  logic                      w_unused;

  // Shared bus: fixed priority so simultaneous strobes still resolve deterministically
  always_comb begin
    w_bus = '0;
    if (PC_Out)       w_bus = r_pc;
    else if (ZHI_Out) w_bus = r_z[2*WIDTH-1:WIDTH];
    else if (ZLO_Out) w_bus = r_z[WIDTH-1:0];
    else if (MDR_Out) w_bus = r_mdr;
    else if (R2_Out)  w_bus = r_r2;
    else if (R4_Out)  w_bus = r_r4;
  end

  assign BusMux_Out = w_bus;
  assign w_mdr_src  = Read ? MData_In : w_bus;

  // Operands are sign-extended explicitly so the product is a true signed 2W-bit result
  assign w_a_s  = r_y;
  assign w_b_s  = w_bus;
  assign w_prod = $signed({{WIDTH{w_a_s[WIDTH-1]}}, w_a_s}) *
                  $signed({{WIDTH{w_b_s[WIDTH-1]}}, w_b_s});

  // ALU: A = Y, B = bus; IncPC overrides the opcode, single-width ops zero the high half
  always_comb begin
    w_alu = '0;
    if (IncPC) begin
      w_alu = {{WIDTH{1'b0}}, w_bus + WIDTH'(1)};
    end else begin
      case (CONTROL)
        OP_ADD:  w_alu = {{WIDTH{1'b0}}, r_y + w_bus};
        OP_SUB:  w_alu = {{WIDTH{1'b0}}, r_y - w_bus};
        OP_MUL:  w_alu = w_prod;
        OP_AND:  w_alu = {{WIDTH{1'b0}}, r_y & w_bus};
        OP_OR:   w_alu = {{WIDTH{1'b0}}, r_y | w_bus};
        OP_NEG:  w_alu = {{WIDTH{1'b0}}, WIDTH'(0) - w_bus};
        OP_NOT:  w_alu = {{WIDTH{1'b0}}, ~w_bus};
        default: w_alu = '0;
      endcase
    end
  end

  // Register file: each register captures its source on its load strobe, all clear on Clear
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_r2  <= '0;
      r_r4  <= '0;
      r_r5  <= '0;
      r_r6  <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_y   <= '0;
      r_z   <= '0;
    end else begin
      if (R2_In)  r_r2  <= w_bus;
      if (R4_In)  r_r4  <= w_bus;
      if (R5_In)  r_r5  <= w_bus;
      if (R6_In)  r_r6  <= w_bus;
      if (PC_In)  r_pc  <= w_bus;
      if (IR_In)  r_ir  <= w_bus;
      if (MAR_In) r_mar <= w_bus;
      if (MDR_In) r_mdr <= w_mdr_src;
      if (Y_In)   r_y   <= w_bus;
      if (Z_In)   r_z   <= w_alu;
    end
  end

  // IR, MAR, R5 and R6 have no bus driver yet; they are kept for observation and later decode
  assign w_unused = ^{r_ir, r_mar, r_r5, r_r6};

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the single-bus datapath with a queue-based scoreboard.
module tb_datapath;

  logic        Clock;
  logic        Clear;
  logic [31:0] MData_In;
  logic        Read;
  logic [4:0]  CONTROL;
  logic        IncPC;
  logic        PC_Out, ZHI_Out, ZLO_Out, MDR_Out, R2_Out, R4_Out;
  logic        PC_In, IR_In, MAR_In, MDR_In, Y_In, Z_In;
  logic        R2_In, R4_In, R5_In, R6_In;
  logic [31:0] BusMux_Out;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  datapath #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear(Clear), .MData_In(MData_In), .Read(Read),
    .CONTROL(CONTROL), .IncPC(IncPC),
    .PC_Out(PC_Out), .ZHI_Out(ZHI_Out), .ZLO_Out(ZLO_Out),
    .MDR_Out(MDR_Out), .R2_Out(R2_Out), .R4_Out(R4_Out),
    .PC_In(PC_In), .IR_In(IR_In), .MAR_In(MAR_In), .MDR_In(MDR_In),
    .Y_In(Y_In), .Z_In(Z_In), .R2_In(R2_In), .R4_In(R4_In),
    .R5_In(R5_In), .R6_In(R6_In), .BusMux_Out(BusMux_Out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op, input logic inc);
    longint sa, sb;
    logic [31:0] r;
    if (inc) return {32'h0, b + 32'd1};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: return 64'(sa * sb);
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = 32'd0 - b;
      5'd6: r = ~b;
      default: r = 32'd0;
    endcase
    return {32'h0, r};
  endfunction

  task automatic clr_strobes();
    Read = 0; CONTROL = 5'd0; IncPC = 0;
    PC_Out = 0; ZHI_Out = 0; ZLO_Out = 0; MDR_Out = 0; R2_Out = 0; R4_Out = 0;
    PC_In = 0; IR_In = 0; MAR_In = 0; MDR_In = 0; Y_In = 0; Z_In = 0;
    R2_In = 0; R4_In = 0; R5_In = 0; R6_In = 0;
  endtask

  // One clock edge, then settle 1 time unit past it and drop all strobes
  task automatic tick();
    @(posedge Clock);
    #1;
    clr_strobes();
  endtask

  task automatic push(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  // Load MDR from memory, then copy it into Y
  task automatic load_y(input logic [31:0] v);
    Read = 1; MDR_In = 1; MData_In = v; tick();
    MDR_Out = 1; Y_In = 1; tick();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Read = 1; MDR_In = 1; MData_In = v; tick();
  endtask

  // Run the ALU on Y and MDR, then read both halves of Z over the bus
  task automatic alu_op(input string t, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic inc);
    logic [63:0] e;
    e = alu_model(a, b, op, inc);
    push({t, "_zlo"}, {32'h0, e[31:0]});
    push({t, "_zhi"}, {32'h0, e[63:32]});
    MDR_Out = 1; CONTROL = op; IncPC = inc; Z_In = 1; tick();
    ZLO_Out = 1; #1; check({32'h0, BusMux_Out});
    ZLO_Out = 0; ZHI_Out = 1; #1; check({32'h0, BusMux_Out});
    clr_strobes();
  endtask

  initial begin
    clr_strobes();
    MData_In = 32'h0;
    Clear = 0;
    #12;

    // Reset state: bus idle and every readable register zero
    push("rst_bus_idle", 64'h0); #1; check({32'h0, BusMux_Out});
    push("rst_pc", 64'h0);  PC_Out = 1;  #1; check({32'h0, BusMux_Out}); PC_Out = 0;
    push("rst_zhi", 64'h0); ZHI_Out = 1; #1; check({32'h0, BusMux_Out}); ZHI_Out = 0;
    push("rst_r4", 64'h0);  R4_Out = 1;  #1; check({32'h0, BusMux_Out}); R4_Out = 0;
    // Loads while Clear is low are ignored
    Read = 1; MDR_In = 1; MData_In = 32'h55; tick();
    push("rst_load_ignored", 64'h0); MDR_Out = 1; #1; check({32'h0, BusMux_Out});
    clr_strobes();
    @(negedge Clock); Clear = 1;
    @(posedge Clock); #1;

    // Register loads through MDR
    load_mdr(32'h22); MDR_Out = 1; R2_In = 1; tick();
    load_mdr(32'h24); MDR_Out = 1; R4_In = 1; tick();
    load_mdr(32'h26); MDR_Out = 1; R5_In = 1; R6_In = 1; tick();
    push("load_r2", 64'h22); R2_Out = 1; #1; check({32'h0, BusMux_Out}); R2_Out = 0;
    push("load_r4", 64'h24); R4_Out = 1; #1; check({32'h0, BusMux_Out}); R4_Out = 0;
    push("load_r5", 64'h26); check({32'h0, dut.r_r5});
    push("load_r6", 64'h26); check({32'h0, dut.r_r6});

    // Instruction fetch
    PC_Out = 1; MAR_In = 1; IncPC = 1; Z_In = 1; tick();
    ZLO_Out = 1; PC_In = 1; Read = 1; MDR_In = 1; MData_In = 32'h4A920000; tick();
    MDR_Out = 1; IR_In = 1; tick();
    push("fetch_pc", 64'h1); PC_Out = 1; #1; check({32'h0, BusMux_Out}); PC_Out = 0;
    push("fetch_mar", 64'h0); check({32'h0, dut.r_mar});
    push("fetch_ir", 64'h4A920000); check({32'h0, dut.r_ir});

    // Multiply R2 * R4 into R5 / R6
    R2_Out = 1; Y_In = 1; tick();
    R4_Out = 1; CONTROL = 5'b00010; Z_In = 1; tick();
    ZLO_Out = 1; R5_In = 1; tick();
    ZHI_Out = 1; R6_In = 1; tick();
    push("mul_r5", 64'h4C8); check({32'h0, dut.r_r5});
    push("mul_r6", 64'h0);   check({32'h0, dut.r_r6});

    // Signed multiply and wrap-around cases
    load_y(32'hFFFFFFFE); load_mdr(32'h3);
    alu_op("smul", 32'hFFFFFFFE, 32'h3, 5'd2, 1'b0);
    load_y(32'hFFFFFFFF); load_mdr(32'h1);
    alu_op("add_wrap", 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0);
    alu_op("sub", 32'hFFFFFFFF, 32'h1, 5'd1, 1'b0);
    load_mdr(32'hFFFFFFFF);
    alu_op("mul_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b0);
    alu_op("inc_wrap", 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b1);

    // Every opcode, plus an undefined one, on a mixed operand pair
    load_y(32'h12345678); load_mdr(32'h0F0F00FF);
    for (int op = 0; op < 8; op++)
      alu_op($sformatf("op%0d", op), 32'h12345678, 32'h0F0F00FF, 5'(op), 1'b0);
    alu_op("op31", 32'h12345678, 32'h0F0F00FF, 5'd31, 1'b0);

    // Bus priority with conflicting strobes
    push("prio_pc_r2", 64'h1); PC_Out = 1; R2_Out = 1; #1; check({32'h0, BusMux_Out});
    clr_strobes();
    push("prio_zlo_mdr", 64'h0F0F00FF & 64'hFFFFFFFF);
    // Z currently holds op31 result (0); MDR holds 0x0F0F00FF, ZLO must win
    exp_q[exp_q.size()-1] = 64'h0;
    ZLO_Out = 1; MDR_Out = 1; #1; check({32'h0, BusMux_Out});
    clr_strobes();
    push("prio_mdr_r4", 64'h0F0F00FF); MDR_Out = 1; R4_Out = 1; #1; check({32'h0, BusMux_Out});
    clr_strobes();

    // Reset in the middle of a cycle clears immediately
    @(posedge Clock); #3; Clear = 0; #1;
    push("midrst_r2", 64'h0); R2_Out = 1; #1; check({32'h0, BusMux_Out});
    push("midrst_y", 64'h0); check({32'h0, dut.r_y});
    push("midrst_pc", 64'h0); check({32'h0, dut.r_pc});
    clr_strobes();
    @(negedge Clock); Clear = 1;
    @(posedge Clock); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-bus 32-bit CPU datapath; the controlling FSM or testbench drives one-hot register in/out strobes.
- Contains:
  - general registers R2, R4, R5, R6
  - PC, IR, MAR, MDR, Y
  - a 64-bit Z result register (ZHI:ZLO)
  - an ALU with add/sub/logic/multiply/increment
- All transfers go over one shared 32-bit bus, which is exported for observation.

Parameters:
- WIDTH, 32, data/bus width. Z is 2*WIDTH.

Ports:
- Clock  input  1  rising-edge clock
- Clear  input  1  asynchronous active-low reset; 0 clears all registers
- MData_In  input  32  memory read data into MDR
- Read  input  1  MDR input mux select: 1 = MData_In, 0 = bus
- CONTROL  input  5  ALU opcode
- IncPC  input  1  ALU override: result = bus + 1
- PC_Out, ZHI_Out, ZLO_Out, MDR_Out, R2_Out, R4_Out  input  1 each  drive the named register onto the bus
- PC_In, IR_In, MAR_In, MDR_In, Y_In, Z_In, R2_In, R4_In, R5_In, R6_In  input  1 each  load the named register from the bus (Z from ALU, MDR from its mux)
- BusMux_Out  output  32  current bus value (combinational)

Behaviour:
- Reset:
  - Clear=0 asynchronously zeroes R2, R4, R5, R6, PC, IR, MAR, MDR, Y and Z[63:0].
  - While Clear=0, loads are ignored.
  - BusMux_Out then reads 0 unless an out strobe selects a (zero) register.
- Bus:
  - Combinational priority mux: PC_Out > ZHI_Out > ZLO_Out > MDR_Out > R2_Out > R4_Out.
  - No strobe asserted → bus = 0.
  - Multiple strobes are a controller error; priority order is still deterministic.
- Register loads:
  - On rising Clock, each register whose _In is 1 captures its source.
  - Register with _In = 0 holds.
  - Several registers may load the same bus value in one cycle (e.g. R5_In and R6_In together).
  - Loads are visible on the bus the same cycle after the edge.
- MDR source: Read=1 → MData_In; else bus. MDR_In gates the load.
- ALU operands: A = Y, B = bus. Combinational, 64-bit result.
- IncPC=1 → result = {32'b0, B+1}; this overrides CONTROL.
- CONTROL encoding (other codes → result 0):
  - 00000 add A+B, zero-extended, carry discarded.
  - 00001 sub A−B, low 32 bits.
  - 00010 mul, signed A×B, full 64-bit product.
  - 00011 and.
  - 00100 or.
  - 00101 neg −B.
  - 00110 not ~B.
- Non-multiply ops place the result in Z[31:0] and zero Z[63:32].
- Z load: on Z_In edge, Z ← ALU result. ZLO_Out drives Z[31:0]; ZHI_Out drives Z[63:32].
- Latency:
  - register→bus→register: 1 cycle.
  - operand through ALU to Z: 1 cycle after both Y and bus are valid.
- Wrap-around:
  - add/inc of 0xFFFFFFFF → 0x00000000.
  - mul 0xFFFFFFFF × 0xFFFFFFFF = 1 (signed), so Z = 0x00000000_00000001.
- IR and MAR have no bus output in this block; they are for observation and future decode/memory.
- Reset asserted mid-operation clears everything immediately; the sequence must restart from the beginning.

Test Plan:
- Reset: pulse Clear low with all strobes 0 → every strobe-selected read yields 0 and BusMux_Out = 0x00000000.
- Load: Read=1, MDR_In, MData_In=0x22, then MDR_Out+R2_In → R2 = 0x22. Repeat with 0x24 → R4; 0x26 → R5 and R6 loaded together in one cycle.
- Fetch: PC=0; PC_Out+MAR_In+IncPC+Z_In, then ZLO_Out+PC_In with Read+MDR_In and MData_In=0x4A920000, then MDR_Out+IR_In → PC = 1, MAR = 0, IR = 0x4A920000.
- Multiply: R2_Out+Y_In; R4_Out+CONTROL=00010+Z_In; ZLO_Out+R5_In; ZHI_Out+R6_In → R5 = 0x000004C8, R6 = 0x00000000.
- Signed multiply: Y=0xFFFFFFFE (−2), bus=0x00000003 → ZHI = 0xFFFFFFFF, ZLO = 0xFFFFFFFA.
- Add/sub wrap and priority: Y=0xFFFFFFFF, bus=1, add → ZLO = 0, ZHI = 0. With PC_Out and R2_Out both high, bus = PC.
